// File: rtl/exception_controller_pkg.sv
// exception_controller_pkg: FSM state encoding and memory-stage cause codes shared with the address checker.
package exception_controller_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_FETCH,
    ST_REDIRECT,
    ST_HALT
  } state_t;
  typedef enum logic [1:0] {
    CAUSE_NONE      = 2'b00,
    CAUSE_INVALID   = 2'b01,
    CAUSE_PROTECTED = 2'b10,
    CAUSE_RESERVED  = 2'b11
  } cause_t;
  localparam logic [7:0] EXC_COUNT_MAX = 8'hff;
  function automatic logic is_fault(input logic [1:0] c);
    return c == CAUSE_INVALID || c == CAUSE_PROTECTED;
  endfunction
endpackage

// File: rtl/exception_controller_if.sv
// exception_controller_if: pipeline-side and vector-fetch signals of the exception controller.
interface exception_controller_if;
  logic [1:0]  i_change_epc;
  logic        i_mem_valid;
  logic [31:0] i_mem_pc;
  logic        o_vec_req;
  logic [31:0] o_vec_addr;
  logic        i_vec_ack;
  logic [31:0] i_vec_data;
  logic        o_flush;
  logic        o_stall;
  logic        o_pc_sel;
  logic [31:0] o_pc_target;
  logic [31:0] o_epc;
  logic [1:0]  o_cause;
  logic        o_halt;
  logic [7:0]  o_exc_count;
  modport master (
    output i_change_epc, i_mem_valid, i_mem_pc, i_vec_ack, i_vec_data,
    input  o_vec_req, o_vec_addr, o_flush, o_stall, o_pc_sel, o_pc_target,
           o_epc, o_cause, o_halt, o_exc_count
  );
  modport slave (
    input  i_change_epc, i_mem_valid, i_mem_pc, i_vec_ack, i_vec_data,
    output o_vec_req, o_vec_addr, o_flush, o_stall, o_pc_sel, o_pc_target,
           o_epc, o_cause, o_halt, o_exc_count
  );
endinterface

// File: rtl/exc_wait_timer.sv
// exc_wait_timer: counts unacknowledged vector-fetch cycles; expired flags the last allowed cycle.
module exc_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= run ? cnt + 1'b1 : '0;
  // cnt lags the FETCH cycle number by one, so TIMEOUT-1 marks the final cycle
  assign expired = run && cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/exception_controller.sv
// exception_controller: captures memory-stage faults, flushes, fetches the handler vector and redirects the PC.
module exception_controller
  import exception_controller_pkg::*;
#(
  parameter logic [31:0] VEC_ADDR_INVALID   = 32'h0000_0002,
  parameter logic [31:0] VEC_ADDR_PROTECTED = 32'h0000_0003,
  parameter int          TIMEOUT            = 15
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  exception_controller_if.slave bus
);
  state_t      state, state_nxt;
  logic [1:0]  cause;
  logic [31:0] epc, target;
  logic [7:0]  exc_count;
  logic        accept, wait_run, expired;
  assign accept   = state == ST_IDLE && bus.i_mem_valid && is_fault(bus.i_change_epc);
  assign wait_run = state == ST_FETCH && !bus.i_vec_ack;
  exc_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .run    (wait_run),
    .expired(expired)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      epc       <= '0;
      cause     <= CAUSE_NONE;
      target    <= '0;
      exc_count <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        epc       <= bus.i_mem_pc;
        cause     <= bus.i_change_epc;
        exc_count <= exc_count + {7'd0, exc_count != EXC_COUNT_MAX};
      end
      if (state == ST_FETCH && bus.i_vec_ack) target <= bus.i_vec_data;
    end
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     state_nxt = accept ? ST_FLUSH : ST_IDLE;
      ST_FLUSH:    state_nxt = ST_FETCH;
      ST_FETCH:    state_nxt = bus.i_vec_ack ? ST_REDIRECT : expired ? ST_HALT : ST_FETCH;
      ST_REDIRECT: state_nxt = ST_IDLE;
      default:     state_nxt = state;
    endcase
  end
  assign bus.o_flush     = state == ST_FLUSH;
  assign bus.o_stall     = state != ST_IDLE;
  assign bus.o_vec_req   = state == ST_FETCH;
  assign bus.o_pc_sel    = state == ST_REDIRECT;
  assign bus.o_halt      = state == ST_HALT;
  assign bus.o_vec_addr  = state != ST_FETCH ? '0 :
                           cause == CAUSE_INVALID ? VEC_ADDR_INVALID : VEC_ADDR_PROTECTED;
  assign bus.o_pc_target = target;
  assign bus.o_epc       = epc;
  assign bus.o_cause     = cause;
  assign bus.o_exc_count = exc_count;
endmodule

// File: doc/exception_controller.md
EXCEPTION_CONTROLLER -- requirements
Module: exception_controller

Interface
REQ-001 Parameter VEC_ADDR_INVALID, default 32'h0000_0002: memory word address holding the invalid-address handler vector.
REQ-002 Parameter VEC_ADDR_PROTECTED, default 32'h0000_0003: memory word address holding the protected-address handler vector.
REQ-003 Parameter TIMEOUT, default 15: maximum wait cycles for i_vec_ack before halt.
REQ-004 i_clk  in  1  sole clock, rising edge.
REQ-005 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 i_change_epc  in  2  cause code from the memory-stage address checker: 00 none, 01 invalid address, 10 protected address, 11 reserved.
REQ-007 i_mem_valid  in  1  memory-stage instruction valid this cycle.
REQ-008 i_mem_pc  in  32  PC of the memory-stage instruction.
REQ-009 o_vec_req  out  1  vector fetch request to data memory.
REQ-010 o_vec_addr  out  32  vector fetch address.
REQ-011 i_vec_ack  in  1  vector data valid.
REQ-012 i_vec_data  in  32  handler address returned.
REQ-013 o_flush  out  1  flush IF/ID/EX/MEM pipeline registers.
REQ-014 o_stall  out  1  freeze PC and pipeline.
REQ-015 o_pc_sel  out  1  select o_pc_target as next PC.
REQ-016 o_pc_target  out  32  handler address.
REQ-017 o_epc  out  32  captured faulting PC.
REQ-018 o_cause  out  2  captured cause code.
REQ-019 o_halt  out  1  sticky fatal halt (vector fetch timeout).
REQ-020 o_exc_count  out  8  saturating count of accepted exceptions.

Function
REQ-021 States IDLE, FLUSH, FETCH, REDIRECT, HALT; one-hot or binary encoding is free.
REQ-022 IDLE: exception accepted when i_mem_valid=1 and i_change_epc is 01 or 10; code 11 and 00 are ignored.
REQ-023 On acceptance, o_epc<=i_mem_pc, o_cause<=i_change_epc, o_exc_count increments (saturates at 255), next state FLUSH.
REQ-024 FLUSH: o_flush=1 and o_stall=1 for exactly one cycle; next state FETCH.
REQ-025 FETCH: o_vec_req=1, o_vec_addr=VEC_ADDR_INVALID for cause 01 else VEC_ADDR_PROTECTED, held stable until i_vec_ack; o_stall=1.
REQ-026 FETCH: on i_vec_ack=1, o_pc_target<=i_vec_data, next state REDIRECT; wait counter clears on FETCH entry.
REQ-027 FETCH: wait counter increments each cycle without ack; when it reaches TIMEOUT without ack, next state HALT; ack in the same cycle as timeout wins.
REQ-028 REDIRECT: o_pc_sel=1 and o_stall=1 for exactly one cycle; next state IDLE.
REQ-029 Accept-to-o_pc_sel latency = 3 cycles plus ack wait (ack on first FETCH cycle: o_pc_sel in cycle 3 after accept edge).
REQ-030 HALT: o_halt=1, o_stall=1, o_vec_req=0; exits only by reset.
REQ-031 Exception inputs while not in IDLE are ignored; o_epc/o_cause not overwritten.
REQ-032 i_vec_ack outside FETCH is ignored.
REQ-033 o_flush, o_pc_sel, o_vec_req are 0 in every state not listed for them; o_stall=0 only in IDLE.
REQ-034 o_epc, o_cause, o_pc_target hold last captured values in IDLE.

Reset
REQ-035 i_rst_n=0 asynchronously forces IDLE, wait counter 0, o_epc=0, o_cause=00, o_pc_target=0, o_exc_count=0, o_halt=0, all strobes 0.
REQ-036 Reset asserted mid-FETCH or in HALT aborts immediately; first post-reset cycle is IDLE.

Structure
REQ-037 State encoding and cause codes (NONE, INVALID, PROTECTED, RESERVED) reside in the shared core package, used also by the address checker.
REQ-038 Optional sub-module exc_wait_timer holds the FETCH wait counter and timeout compare; no other hierarchy.

Verification
REQ-039 Cause 01, i_mem_pc=0x0000_0040, ack next cycle with data 0x0000_0200 -> flush 1 cycle, o_vec_addr=0x2, o_pc_sel with target 0x200, o_epc=0x40, o_cause=01.
REQ-040 Cause 10, i_mem_pc=0x0000_0080, ack after 5 cycles data 0x300 -> o_vec_addr=0x3 held 6 cycles, target 0x300.
REQ-041 Cause 01, no ack -> o_halt=1 after 15 FETCH cycles, persists until reset; ack on cycle 15 instead -> REDIRECT, no halt.
REQ-042 Second cause 10 during FETCH of first -> ignored, o_epc unchanged, o_exc_count=1.
REQ-043 Cause 11 or i_mem_valid=0 with cause 01 -> no state change, count stays 0.
REQ-044 Reset pulsed mid-FETCH -> all outputs reset values asynchronously, IDLE next cycle; 256 exceptions -> o_exc_count=255.
